rr_arbiter: RTL
===============

# rr_arbiter

Parametrised N-requester round-robin arbiter with a bounded grant-hold time. It is the successor to the two-requester fixed-priority arbiter. It sits between N bus masters and one shared resource. It issues registered one-hot grants, rotates priority past each owner on release, and forces release after MAX_HOLD consecutive granted cycles so no requester can starve the others.

## Interface
- N, default 4: number of requesters; legal range 2..32.
- MAX_HOLD, default 8: maximum consecutive cycles one owner may hold the grant; must be ≥ 1; MAX_HOLD = 1 gives pure per-cycle round-robin.
- IDW (localparam) = $clog2(N).
- CW (localparam) = $clog2(MAX_HOLD+1).
- One clock; reset is asynchronous and active-low.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  N  request vector; req[i] is high while requester i wants the resource.
- gnt  output  N  registered grant; one-hot or all zero.
- gnt_valid  output  1  registered; equals |gnt.
- gnt_id  output  IDW  registered binary index of the granted requester; 0 when gnt_valid = 0.

## Operation
- **State:** FSM with states IDLE and GRANT, plus:
  - owner (IDW bits),
  - rotating pointer ptr (IDW bits): index of the highest-priority requester,
  - hold counter hold_cnt (CW bits).
- **Reset (reset_n low, asynchronous, takes effect immediately):** state = IDLE, gnt = 0, gnt_valid = 0, gnt_id = 0, ptr = 0, hold_cnt = 0, owner = 0.
- **Search order:** starting at index s, scan s, s+1, …, N-1, 0, …, s-1; pick the first i with req[i] = 1.
- **IDLE:**
  - req = 0: stay in IDLE.
  - Otherwise, at the next edge: grant the search winner from s = ptr, go to GRANT, hold_cnt = 1.
- **GRANT, owner k, evaluated at each edge:**
  - **Keep:** req[k] = 1 and hold_cnt < MAX_HOLD → keep gnt, hold_cnt += 1.
  - **Release:** req[k] = 0, or hold_cnt == MAX_HOLD → ptr = (k+1) mod N, then search from s = (k+1) mod N:
    - Winner found (may be k itself if k is still the only requester): grant it on this same edge with no idle gap; hold_cnt = 1; stay in GRANT.
    - No requester: go to IDLE, gnt = 0, hold_cnt = 0.
- **Invariants, checked every cycle:**
  - gnt is one-hot or zero.
  - gnt_valid == |gnt.
  - gnt[gnt_id] == 1 whenever gnt_valid = 1.
  - gnt[i] rises only if req[i] was 1 at that edge.
  - hold_cnt never exceeds MAX_HOLD.
- **Wrap-around:** ptr increment and the search index are computed modulo N, which need not be a power of 2.
- **Single requester:** on expiry the same requester is regranted; gnt stays high continuously and hold_cnt restarts at 1.
- **Requester deasserts and re-asserts within the same cycle as the release:** not possible. req is sampled only at the edge, so the edge value decides.

## Timing
- **Grant latency:** 1 cycle. If req is sampled high at edge t and the requester wins, gnt is visible after edge t.
- **Release latency:** 1 cycle. The edge at which req[k] is seen low moves gnt to the next winner or to 0.
- **Handoff:** zero bubble cycles between owners.
- **Worst-case wait for a continuously requesting i:** (N-1)·MAX_HOLD cycles after any other owner is first granted.
- **Outputs:** all registered, with no combinational path from req to gnt.
- **Reset mid-grant:** gnt drops asynchronously on reset_n falling. After reset_n rises, arbitration restarts from ptr = 0 on the first edge.

## Test plan
All scenarios use N = 4 and MAX_HOLD = 4.
- **Reset:** reset_n = 0 with req = 4'b1111 → gnt = 0, gnt_valid = 0, gnt_id = 0. After release, the first edge gives gnt = 4'b0001, gnt_id = 0. Pull reset_n low mid-grant → gnt = 0 before the next edge.
- **Lone requester:** req = 4'b0100 held for 12 cycles → gnt = 4'b0100 and gnt_id = 2 on every cycle from the first edge, with no gap at the expiries (cycles 4 and 8).
- **Full contention:** req = 4'b1111 held → gnt = 0001 ×4, 0010 ×4, 0100 ×4, 1000 ×4, then 0001 again (wrap).
- **Early release:** req = 4'b0011 from reset → gnt = 0001. Drop req[0] after 2 granted cycles → gnt = 0010 on the next edge with no bubble.
- **Pointer retention:** from the end of the early-release scenario, req goes to 0 → gnt = 0 and IDLE on the next edge. Then req = 4'b0011 → winner is requester 0 (ptr = 2, search 2, 3, 0) → gnt = 0001.
- **Random stress:** 10k cycles of random req → invariants always hold, and no continuously requesting index waits more than 12 cycles.

Source files
------------

// File: rtl/rr_arbiter.sv
// N-requester round-robin arbiter with registered one-hot grant and a bounded
// grant-hold time; priority rotates past each owner when it releases.
module rr_arbiter #(
   parameter  int N        = 4,
   parameter  int MAX_HOLD = 8,
   localparam int IDW      = $clog2(N),
   localparam int CW       = $clog2(MAX_HOLD + 1)
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] owner_q, owner_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [CW-1:0]  hold_q, hold_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0] gntId_q, gntId_d;
   logic           gntValid_q, gntValid_d;

   logic [IDW-1:0] nextPtr;
   logic [IDW-1:0] searchStart;
   logic [IDW-1:0] winner;
   logic           found;
   logic [IDW:0]   searchSum;

   assign nextPtr = (owner_q == IDW'(N - 1)) ? '0 : owner_q + IDW'(1);

   // Circular priority search; the extra sum bit lets the wrap work for any N.
   always_comb begin
      searchStart = (state_q == IDLE) ? ptr_q : nextPtr;
      winner      = '0;
      found       = 1'b0;
      searchSum   = '0;
      for (int j = 0; j < N; j++) begin
         searchSum = {1'b0, searchStart} + (IDW + 1)'(j);
         if (searchSum >= (IDW + 1)'(N)) begin
            searchSum = searchSum - (IDW + 1)'(N);
         end
         if (!found && req[searchSum[IDW-1:0]]) begin
            winner = searchSum[IDW-1:0];
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = GRANT;
               owner_d = winner;
               hold_d  = CW'(1);
            end
         end
         GRANT: begin
            if (req[owner_q] && (hold_q < CW'(MAX_HOLD))) begin
               hold_d = hold_q + CW'(1);
            end else begin
               ptr_d = nextPtr;
               if (found) begin
                  owner_d = winner;
                  hold_d  = CW'(1);
               end else begin
                  state_d = IDLE;
                  hold_d  = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Outputs are registered copies of the next owner, so there is no req-to-gnt path.
      gntValid_d = (state_d == GRANT);
      gnt_d      = gntValid_d ? (N'(1) << owner_d) : '0;
      gntId_d    = gntValid_d ? owner_d : '0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         ptr_q      <= '0;
         hold_q     <= '0;
         gnt_q      <= '0;
         gntId_q    <= '0;
         gntValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         hold_q     <= hold_d;
         gnt_q      <= gnt_d;
         gntId_q    <= gntId_d;
         gntValid_q <= gntValid_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = gntValid_q;
   assign gnt_id    = gntId_q;

endmodule
